// File: rtl/inst_fetcher_pkg.sv
// Shared fetch-stage types and constants: address/instruction words and FSM encoding.
package inst_fetcher_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned INST_W   = 32;
    localparam int unsigned STATUS_W = 1;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [INST_W-1:0] inst_t;

    localparam logic  TRUE       = 1'b1;
    localparam logic  FALSE      = 1'b0;
    localparam inst_t ZERO_WORD  = '0;
    localparam addr_t ZERO_ADDR  = '0;
    localparam addr_t INST_BYTES = 32'd4;

    typedef enum logic [STATUS_W-1:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } status_t;

endpackage

// File: rtl/inst_fetcher_icache.sv
// Direct-mapped instruction cache, one word per line; combinational lookup, registered fill.
module inst_fetcher_icache
    import inst_fetcher_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned TAG_W      = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] lookup_index,
    input  logic [TAG_W-1:0]      lookup_tag,
    output logic                  lookup_hit_c,
    output inst_t                 lookup_data_c,
    input  logic                  fill_en,
    input  logic [INDEX_BITS-1:0] fill_index,
    input  logic [TAG_W-1:0]      fill_tag,
    input  inst_t                 fill_data
);

    localparam int unsigned LINES = 1 << INDEX_BITS;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [LINES];
    inst_t            data [LINES];

    // Only valid bits need reset; tag/data are qualified by valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (fill_en) begin
            valid[fill_index] <= TRUE;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tags[fill_index] <= fill_tag;
            data[fill_index] <= fill_data;
        end
    end

    assign lookup_hit_c  = valid[lookup_index] && (tags[lookup_index] == lookup_tag);
    assign lookup_data_c = data[lookup_index];

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: serves hits from the icache, issues one outstanding miss to memory.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int unsigned ICACHE_INDEX_BITS = 6,
    parameter logic [31:0] RESET_PC          = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        start_query_signal,
    output logic [31:0] pc_to_mem,
    input  logic        finish_query_signal,
    input  logic [31:0] inst_from_mem,
    input  logic        stall_from_queue,
    input  logic        rollback_flag,
    input  logic [31:0] rollback_pc,
    output logic        inst_valid_to_queue,
    output logic [31:0] inst_to_queue,
    output logic [31:0] inst_pc_to_queue
);

    localparam int unsigned TAG_LSB = ICACHE_INDEX_BITS + 2;
    localparam int unsigned TAG_W   = ADDR_W - TAG_LSB;

    status_t state, state_next;
    addr_t   pc, pc_next, pc_to_mem_next, inst_pc_next;
    inst_t   inst_next;
    logic    start_next, valid_next;

    logic    hit_c;
    inst_t   hit_data_c;
    logic    fill_en_c;

    assign fill_en_c = rdy && (state == WAIT_MEM) && finish_query_signal;

    inst_fetcher_icache #(
        .INDEX_BITS(ICACHE_INDEX_BITS),
        .TAG_W     (TAG_W)
    ) u_icache (
        .clk          (clk),
        .rst          (rst),
        .lookup_index (pc[TAG_LSB-1:2]),
        .lookup_tag   (pc[ADDR_W-1:TAG_LSB]),
        .lookup_hit_c (hit_c),
        .lookup_data_c(hit_data_c),
        .fill_en      (fill_en_c),
        .fill_index   (pc_to_mem[TAG_LSB-1:2]),
        .fill_tag     (pc_to_mem[ADDR_W-1:TAG_LSB]),
        .fill_data    (inst_from_mem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A request stays outstanding until finish, even across redirects.
    always_comb begin
        state_next = state;
        if (rdy) begin
            case (state)
                IDLE:     if (!rollback_flag && !stall_from_queue && !hit_c) state_next = WAIT_MEM;
                WAIT_MEM: if (finish_query_signal) state_next = IDLE;
                default:  state_next = IDLE;
            endcase
        end
    end

    // Pulses default low; everything else holds unless the FSM updates it.
    always_comb begin
        pc_next        = pc;
        pc_to_mem_next = pc_to_mem;
        inst_next      = inst_to_queue;
        inst_pc_next   = inst_pc_to_queue;
        start_next     = FALSE;
        valid_next     = FALSE;
        if (rdy) begin
            case (state)
                IDLE: begin
                    if (rollback_flag) begin
                        pc_next = rollback_pc;
                    end else if (!stall_from_queue) begin
                        if (hit_c) begin
                            valid_next   = TRUE;
                            inst_next    = hit_data_c;
                            inst_pc_next = pc;
                            pc_next      = pc + INST_BYTES;
                        end else begin
                            start_next     = TRUE;
                            pc_to_mem_next = pc;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (rollback_flag) pc_next = rollback_pc;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc                  <= RESET_PC;
            pc_to_mem           <= ZERO_ADDR;
            inst_to_queue       <= ZERO_WORD;
            inst_pc_to_queue    <= ZERO_ADDR;
            start_query_signal  <= FALSE;
            inst_valid_to_queue <= FALSE;
        end else begin
            pc                  <= pc_next;
            pc_to_mem           <= pc_to_mem_next;
            inst_to_queue       <= inst_next;
            inst_pc_to_queue    <= inst_pc_next;
            start_query_signal  <= start_next;
            inst_valid_to_queue <= valid_next;
        end
    end

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher with a latency-programmable memory responder.
module tb_inst_fetcher;

    logic        clk, rst, rdy;
    logic        start_query_signal, finish_query_signal;
    logic [31:0] pc_to_mem, inst_from_mem;
    logic        stall_from_queue, rollback_flag;
    logic [31:0] rollback_pc;
    logic        inst_valid_to_queue;
    logic [31:0] inst_to_queue, inst_pc_to_queue;

    inst_fetcher dut (
        .clk                (clk),
        .rst                (rst),
        .rdy                (rdy),
        .start_query_signal (start_query_signal),
        .pc_to_mem          (pc_to_mem),
        .finish_query_signal(finish_query_signal),
        .inst_from_mem      (inst_from_mem),
        .stall_from_queue   (stall_from_queue),
        .rollback_flag      (rollback_flag),
        .rollback_pc        (rollback_pc),
        .inst_valid_to_queue(inst_valid_to_queue),
        .inst_to_queue      (inst_to_queue),
        .inst_pc_to_queue   (inst_pc_to_queue)
    );

    int vecs = 0;
    int errs = 0;
    int cyc = 0;
    int mem_lat = 2;
    int extra_q = 0;
    bit pend = 0;
    int p_cnt = 0;
    logic [31:0] p_addr;
    logic [31:0] q_log[$];
    logic [31:0] d_pc[$];
    logic [31:0] d_inst[$];
    int          d_cyc[$];

    function automatic logic [31:0] model_inst(input logic [31:0] a);
        if (a == 32'h0) return 32'h00100513;
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst = 1; rdy = 1; stall_from_queue = 0; rollback_flag = 0; rollback_pc = 0;
    end

    // Memory responder and delivery monitor, sampled just after each rising edge.
    initial begin
        finish_query_signal = 0;
        inst_from_mem = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            finish_query_signal = 0;
            if (inst_valid_to_queue) begin
                d_pc.push_back(inst_pc_to_queue);
                d_inst.push_back(inst_to_queue);
                d_cyc.push_back(cyc);
            end
            if (rst) begin
                pend = 0;
            end else begin
                if (pend) begin
                    if (p_cnt == 0) begin
                        finish_query_signal = 1;
                        inst_from_mem = model_inst(p_addr);
                        pend = 0;
                    end else begin
                        p_cnt = p_cnt - 1;
                    end
                end
                if (start_query_signal) begin
                    q_log.push_back(pc_to_mem);
                    if (pend) extra_q = extra_q + 1;
                    else begin
                        pend = 1; p_addr = pc_to_mem; p_cnt = mem_lat;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic clear_logs();
        q_log.delete(); d_pc.delete(); d_inst.delete(); d_cyc.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; rdy = 1; stall_from_queue = 0; rollback_flag = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        clear_logs();
    endtask

    task automatic rewind(input logic [31:0] target);
        @(negedge clk);
        rollback_flag = 1; rollback_pc = target;
        @(negedge clk);
        rollback_flag = 0;
        clear_logs();
    endtask

    task automatic wait_deliv(input int n, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (d_pc.size() >= n) begin ok = 1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_query(input int n, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (q_log.size() >= n) begin ok = 1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bit ok;
        @(negedge clk);
        rst = 1;
        repeat (2) @(negedge clk);
        vecs++; if (start_query_signal !== 1'b0) begin errs++; $display("FAIL rst_start got=%b want=0", start_query_signal); end
        vecs++; if (inst_valid_to_queue !== 1'b0) begin errs++; $display("FAIL rst_valid got=%b want=0", inst_valid_to_queue); end
        vecs++; if (pc_to_mem !== 32'h0) begin errs++; $display("FAIL rst_pc_to_mem got=%h want=0", pc_to_mem); end
        vecs++; if (inst_to_queue !== 32'h0) begin errs++; $display("FAIL rst_inst got=%h want=0", inst_to_queue); end
        vecs++; if (inst_pc_to_queue !== 32'h0) begin errs++; $display("FAIL rst_inst_pc got=%h want=0", inst_pc_to_queue); end
        // Abandon a long miss with reset, then expect a clean restart at RESET_PC.
        mem_lat = 20;
        rst = 0;
        clear_logs();
        wait_query(1, 20, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL rst_first_query got=none want=query"); end
        do_reset();
        mem_lat = 2;
        wait_query(1, 20, ok);
        vecs++; if (q_log.size() < 1 || q_log[0] !== 32'h0) begin errs++; $display("FAIL rst_restart_query got=%h want=0", (q_log.size() > 0) ? q_log[0] : 32'hxxxxxxxx); end
        wait_deliv(1, 30, ok);
        vecs++; if (!ok || d_inst[0] !== 32'h00100513) begin errs++; $display("FAIL rst_restart_inst got=%h want=00100513", ok ? d_inst[0] : 32'hxxxxxxxx); end
    endtask

    task automatic test_cold_miss();
        bit ok;
        do_reset();
        wait_query(1, 20, ok);
        vecs++; if (!ok || q_log[0] !== 32'h0) begin errs++; $display("FAIL cold_query got=%h want=0", ok ? q_log[0] : 32'hxxxxxxxx); end
        wait_deliv(1, 30, ok);
        vecs++; if (!ok || d_inst[0] !== 32'h00100513) begin errs++; $display("FAIL cold_inst got=%h want=00100513", ok ? d_inst[0] : 32'hxxxxxxxx); end
        vecs++; if (!ok || d_pc[0] !== 32'h0) begin errs++; $display("FAIL cold_inst_pc got=%h want=0", ok ? d_pc[0] : 32'hxxxxxxxx); end
        wait_query(2, 30, ok);
        vecs++; if (!ok || q_log[1] !== 32'h4) begin errs++; $display("FAIL cold_next_query got=%h want=4", ok ? q_log[1] : 32'hxxxxxxxx); end
    endtask

    task automatic test_hit_stream();
        bit ok;
        do_reset();
        wait_deliv(4, 100, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL stream_preload got=%0d want=4", d_pc.size()); end
        rewind(32'h0);
        wait_deliv(4, 50, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL stream_count got=%0d want=4", d_pc.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                vecs++; if (d_pc[i] !== 32'(4 * i)) begin errs++; $display("FAIL stream_pc%0d got=%h want=%h", i, d_pc[i], 32'(4 * i)); end
                vecs++; if (d_cyc[i] != d_cyc[0] + i) begin errs++; $display("FAIL stream_cycle%0d got=%0d want=%0d", i, d_cyc[i], d_cyc[0] + i); end
            end
            vecs++; if (d_inst[3] !== model_inst(32'hC)) begin errs++; $display("FAIL stream_inst3 got=%h want=%h", d_inst[3], model_inst(32'hC)); end
        end
        vecs++; if (q_log.size() != 0) begin errs++; $display("FAIL stream_no_query got=%0d want=0", q_log.size()); end
    endtask

    task automatic test_stall();
        bit ok;
        rewind(32'h0);
        wait_deliv(1, 40, ok);
        stall_from_queue = 1;
        repeat (3) @(negedge clk);
        vecs++; if (d_pc.size() != 1) begin errs++; $display("FAIL stall_no_emit got=%0d want=1", d_pc.size()); end
        stall_from_queue = 0;
        wait_deliv(3, 20, ok);
        vecs++; if (!ok || d_pc[1] !== 32'h4) begin errs++; $display("FAIL stall_resume_pc got=%h want=4", ok ? d_pc[1] : 32'hxxxxxxxx); end
        vecs++; if (!ok || d_cyc[1] - d_cyc[0] != 4) begin errs++; $display("FAIL stall_gap got=%0d want=4", ok ? d_cyc[1] - d_cyc[0] : -1); end
        vecs++; if (!ok || d_pc[2] !== 32'h8) begin errs++; $display("FAIL stall_next_pc got=%h want=8", ok ? d_pc[2] : 32'hxxxxxxxx); end
    endtask

    task automatic test_rollback_mid_miss();
        bit ok;
        mem_lat = 5;
        rewind(32'h100);
        wait_query(1, 40, ok);
        vecs++; if (!ok || q_log[0] !== 32'h100) begin errs++; $display("FAIL rbm_query got=%h want=100", ok ? q_log[0] : 32'hxxxxxxxx); end
        repeat (2) @(negedge clk);
        rollback_flag = 1; rollback_pc = 32'h40;
        @(negedge clk);
        rollback_flag = 0;
        wait_query(2, 40, ok);
        vecs++; if (!ok || q_log[1] !== 32'h40) begin errs++; $display("FAIL rbm_redirect_query got=%h want=40", ok ? q_log[1] : 32'hxxxxxxxx); end
        vecs++; if (d_pc.size() != 0) begin errs++; $display("FAIL rbm_no_deliver got=%0d want=0", d_pc.size()); end
        mem_lat = 2;
        rewind(32'h100);
        wait_deliv(1, 40, ok);
        vecs++; if (!ok || d_pc[0] !== 32'h100) begin errs++; $display("FAIL rbm_fill_kept_pc got=%h want=100", ok ? d_pc[0] : 32'hxxxxxxxx); end
        vecs++; if (!ok || d_inst[0] !== model_inst(32'h100)) begin errs++; $display("FAIL rbm_fill_kept_inst got=%h want=%h", ok ? d_inst[0] : 32'hxxxxxxxx, model_inst(32'h100)); end
        vecs++; if (q_log.size() != 0) begin errs++; $display("FAIL rbm_fill_hit got=%0d want=0", q_log.size()); end
    endtask

    task automatic test_conflict_rdy();
        bit ok;
        do_reset();
        wait_deliv(1, 40, ok);
        rewind(32'h100);
        wait_deliv(1, 60, ok);
        vecs++; if (q_log.size() < 1 || q_log[0] !== 32'h100) begin errs++; $display("FAIL conf_miss_100 got=%h want=100", (q_log.size() > 0) ? q_log[0] : 32'hxxxxxxxx); end
        vecs++; if (!ok || d_pc[0] !== 32'h100) begin errs++; $display("FAIL conf_deliver_100 got=%h want=100", ok ? d_pc[0] : 32'hxxxxxxxx); end
        rewind(32'h0);
        wait_query(1, 40, ok);
        vecs++; if (!ok || q_log[0] !== 32'h0) begin errs++; $display("FAIL conf_remiss_0 got=%h want=0", ok ? q_log[0] : 32'hxxxxxxxx); end
        wait_deliv(1, 40, ok);
        vecs++; if (!ok || d_inst[0] !== 32'h00100513) begin errs++; $display("FAIL conf_refill_0 got=%h want=00100513", ok ? d_inst[0] : 32'hxxxxxxxx); end

        do_reset();
        wait_deliv(4, 100, ok);
        rewind(32'h0);
        wait_deliv(1, 40, ok);
        rdy = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vecs++; if (inst_valid_to_queue !== 1'b0 || start_query_signal !== 1'b0) begin errs++; $display("FAIL rdy_pulses%0d got=%b%b want=00", i, inst_valid_to_queue, start_query_signal); end
        end
        vecs++; if (inst_pc_to_queue !== 32'h0 || inst_to_queue !== 32'h00100513) begin errs++; $display("FAIL rdy_hold got=%h/%h want=0/00100513", inst_pc_to_queue, inst_to_queue); end
        vecs++; if (d_pc.size() != 1 || q_log.size() != 0) begin errs++; $display("FAIL rdy_quiet got=%0d/%0d want=1/0", d_pc.size(), q_log.size()); end
        rdy = 1;
        wait_deliv(2, 20, ok);
        vecs++; if (!ok || d_pc[1] !== 32'h4) begin errs++; $display("FAIL rdy_resume_pc got=%h want=4", ok ? d_pc[1] : 32'hxxxxxxxx); end
        vecs++; if (!ok || d_cyc[1] - d_cyc[0] != 6) begin errs++; $display("FAIL rdy_gap got=%0d want=6", ok ? d_cyc[1] - d_cyc[0] : -1); end
    endtask

    task automatic test_wrap();
        bit ok;
        @(negedge clk);
        rst = 1;
        repeat (3) @(negedge clk);
        rollback_flag = 1; rollback_pc = 32'hFFFF_FFFC;
        rst = 0;
        clear_logs();
        @(negedge clk);
        rollback_flag = 0;
        wait_query(1, 20, ok);
        vecs++; if (!ok || q_log[0] !== 32'hFFFF_FFFC) begin errs++; $display("FAIL wrap_query got=%h want=fffffffc", ok ? q_log[0] : 32'hxxxxxxxx); end
        wait_deliv(1, 30, ok);
        vecs++; if (!ok || d_pc[0] !== 32'hFFFF_FFFC) begin errs++; $display("FAIL wrap_inst_pc got=%h want=fffffffc", ok ? d_pc[0] : 32'hxxxxxxxx); end
        vecs++; if (!ok || d_inst[0] !== model_inst(32'hFFFF_FFFC)) begin errs++; $display("FAIL wrap_inst got=%h want=%h", ok ? d_inst[0] : 32'hxxxxxxxx, model_inst(32'hFFFF_FFFC)); end
        wait_query(2, 30, ok);
        vecs++; if (!ok || q_log[1] !== 32'h0) begin errs++; $display("FAIL wrap_next_query got=%h want=0", ok ? q_log[1] : 32'hxxxxxxxx); end
        vecs++; if (extra_q != 0) begin errs++; $display("FAIL single_outstanding got=%0d want=0", extra_q); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit_stream();
        test_stall();
        test_rollback_mid_miss();
        test_conflict_rdy();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
- Instruction fetch stage with a direct-mapped instruction cache.
- Sits directly upstream of the memory controller's IF port and downstream-feeds the decoder/dispatch queue.
- Serves hits in one cycle. On a miss, issues a single query pulse to the memory controller and fills the line when the controller's finish pulse returns.
- Accepts a redirect (rollback/jump) from the commit side.

Parameters:
- ICACHE_INDEX_BITS, 6, log2 of cache line count (64 lines, one 32-bit instruction per line).
- RESET_PC, 32'h0, PC loaded on reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global enable; when low, all state holds.
- start_query_signal  out  1  one-cycle pulse requesting a 4-byte fetch.
- pc_to_mem  out  32  fetch address; held stable from the pulse until finish.
- finish_query_signal  in  1  one-cycle pulse from the memory controller; inst_from_mem is valid.
- inst_from_mem  in  32  fetched instruction, little-endian assembled.
- stall_from_queue  in  1  downstream queue full; do not emit.
- rollback_flag  in  1  redirect request (misprediction/jump).
- rollback_pc  in  32  redirect target, 4-byte aligned.
- inst_valid_to_queue  out  1  one-cycle pulse; instruction delivered.
- inst_to_queue  out  32  instruction word.
- inst_pc_to_queue  out  32  PC of the delivered instruction.

Behaviour:
- Clocking: one clock (clk). Reset is synchronous and active-high on rst.
- Reset: pc = RESET_PC, state = IDLE, all valid bits cleared, start_query_signal = 0, inst_valid_to_queue = 0, pc_to_mem = 0, inst_to_queue = 0, inst_pc_to_queue = 0, discard = 0. Reset mid-miss abandons the request; a later finish pulse while in IDLE is ignored.
- rdy low: start_query_signal and inst_valid_to_queue are driven 0. All other registers hold.
- Cache address fields: index = pc[ICACHE_INDEX_BITS+1:2]; tag = pc[31:ICACHE_INDEX_BITS+2]; pc[1:0] ignored. Each line holds valid, tag and data. Storage is registers; lookup is combinational.
- Output pulses: start_query_signal and inst_valid_to_queue default to 0 every cycle. Each is high for exactly one cycle when asserted.
- IDLE, priority order:
  1. rollback_flag: pc <= rollback_pc; no emit, no query.
  2. stall_from_queue: hold.
  3. Hit: inst_valid_to_queue <= 1, inst_to_queue <= line data, inst_pc_to_queue <= pc, pc <= pc + 4. Wraps mod 2^32, so 32'hFFFFFFFC -> 0.
  4. Miss: start_query_signal <= 1, pc_to_mem <= pc, state <= WAIT_MEM.
- Hit latency: one cycle from pc update to inst_valid. Back-to-back hits give one instruction per cycle.
- WAIT_MEM:
  - Never issues another query; only one request is ever outstanding.
  - rollback_flag: pc <= rollback_pc. The request cannot be cancelled; wait for finish.
  - finish_query_signal: write line[index(pc_to_mem)] = {1, tag(pc_to_mem), inst_from_mem}, state <= IDLE.
  - The instruction is delivered on the next IDLE cycle via the hit path. If a redirect occurred, the fill is still kept (the address is correct), and pc already holds the redirect target.
- Simultaneous finish and rollback in WAIT_MEM: fill the line, pc <= rollback_pc, go to IDLE.
- Miss on a conflicting index overwrites the line; no replacement policy.
- Cache is never invalidated except by reset; self-modifying code is unsupported.

Decomposition:
- Shared constants header (same header as the rest of the core) supplies:
  - ADDR_TYPE [31:0], INST_TYPE [31:0];
  - TRUE/FALSE, ZERO_WORD, ZERO_ADDR;
  - STATUS_TYPE width for the 2-state FSM encoding.
- One sub-module, icache:
  - lookup port: addr in; hit and data out, combinational;
  - fill port: en, addr, data;
  - sync reset clears valid bits.
- inst_fetcher keeps the FSM, pc and handshakes.

Test Plan:
1. Cold miss: reset, memory[0..3] = 13 05 10 00. Expect start_query_signal pulse with pc_to_mem = 0; after the finish pulse, inst_valid_to_queue pulse with inst_to_queue = 32'h00100513, inst_pc_to_queue = 0, then a query at 4.
2. Hit streaming: preload addresses 0..12 through misses, rollback to 0. Expect four consecutive inst_valid pulses with PCs 0, 4, 8, 12 and no start_query_signal.
3. Stall: stall_from_queue = 1 for 3 cycles during a hit stream. Expect no inst_valid and pc frozen; streaming resumes at the same PC when stall drops.
4. Rollback mid-miss: miss at 32'h100, rollback_pc = 32'h40 two cycles later, finish arrives. Expect the line for 0x100 filled, no delivery of 0x100, next query at 32'h40.
5. Conflict and rdy: fetch 0x000 then 0x100 (same index, 64 lines). Expect the second access to miss and 0x000 to miss again after that. With rdy = 0 held 5 cycles mid-hit-stream, expect no pulses and state unchanged.
6. Wrap: rollback to 32'hFFFFFFFC and serve that line. Expect inst_pc_to_queue = 32'hFFFFFFFC, then the next query at pc_to_mem = 0.
